resource_grant_server: RTL and testbench
========================================

Name: resource_grant_server

Overview:
- Resource-side responder for the pipeline arbitration protocol. Pipelines raise a request and present operand data; this block arbitrates round-robin and grants one requester at a time.
- It issues the granted operand to the shared resource with a one-hot requester tag, then waits for the tagged result and routes it back to the granted requester.
- Sits between the pipeline_top instances and the shared resource in place of the free-running arbiter plus the grant-driven mux. It adds a response handshake, a timeout and error reporting.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- DATA_W, 32, operand/result width
- TIMEOUT, 15, max WAIT cycles before abort (1..255)

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- req  input  NUM_REQ  per-requester request level
- req_data  input  NUM_REQ*DATA_W  operands, requester i at bits [i*DATA_W +: DATA_W]
- grant  output  NUM_REQ  one-hot grant, registered
- stall  output  NUM_REQ  per-requester stall, combinational
- rsp_valid  output  NUM_REQ  one-hot response strobe, registered
- rsp_data  output  DATA_W  response data, registered
- res_in  output  DATA_W  operand to resource
- res_in_valid  output  NUM_REQ  one-hot tag to resource
- res_out  input  DATA_W  resource result
- res_out_valid  input  NUM_REQ  one-hot tag of result
- timeout_err  output  1  one-cycle pulse on abort
- tag_err  output  1  one-cycle pulse on mismatched result tag
- busy  output  1  state != IDLE

Behaviour:
- Clock and reset: single clock clk. reset is asynchronous and active-high.
- Reset values:
  - state=IDLE, rr_ptr=0, timer=0.
  - grant=0, rsp_valid=0, rsp_data=0, timeout_err=0, tag_err=0.
  - res_in_valid=0, res_in=0.
- Reset mid-transaction: the in-flight result is dropped. A late res_out_valid arriving in IDLE is ignored, with no tag_err.
- FSM IDLE -> ISSUE -> WAIT -> IDLE.
- IDLE:
  - If req is nonzero, pick the first set bit scanning from rr_ptr upward with wrap.
  - Register grant to that one-hot value and go to ISSUE. grant is visible the cycle after req is sampled.
  - If req is 0, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - res_in_valid=grant and res_in=req_data of the granted index, both combinational from the current cycle.
  - timer cleared; go to WAIT.
  - The requester must hold its data while granted and stalled.
- WAIT:
  - timer increments each cycle.
  - Result match (res_out_valid==grant): rsp_data<=res_out and rsp_valid<=grant on the next edge. Also grant<=0, rr_ptr<=(granted index+1) mod NUM_REQ, state<=IDLE.
  - Mismatched tag (res_out_valid nonzero and !=grant): tag_err pulses, the result is discarded, and WAIT continues.
  - Timeout (timer==TIMEOUT with no match): timeout_err pulses, rsp_valid stays 0, grant<=0, rr_ptr advances as on success, state<=IDLE.
  - Simultaneous match and timeout in the same cycle: the match wins.
- Request drop: dropping req after grant does not abort the transaction. The response is still delivered.
- Back-to-back: a requester holding req after its response is considered in the next IDLE cycle under round-robin, so others are not starved. Throughput is at most one transaction per 3+resource latency cycles.
- stall[i] = req[i] & ~rsp_valid[i], combinational. A requester is stalled from request until the cycle its response strobes. After a timeout, stall stays high and the requester re-arbitrates.
- rsp_valid and the error pulses are single-cycle. rsp_data holds its value until the next response.
- Invariants:
  - grant is always one-hot or zero.
  - res_in_valid is nonzero only in ISSUE.
  - res_in_valid equals grant whenever it is nonzero.

Decomposition:
- Shared package holds:
  - state enum {IDLE, ISSUE, WAIT}, 2 bits
  - default DATA_W, NUM_REQ and TIMEOUT constants
- Sub-module rr_pick: combinational round-robin selector with inputs req and rr_ptr, outputs one-hot pick and its index. Reusable by other arbitration blocks.

Test Plan:
- Single request, resource latency 2: req=01, req_data[0]=0x0000_00A5 at cycle 0 -> grant=01 at 1, res_in=0xA5 with res_in_valid=01 at 1. Result 0x1234 tagged 01 at cycle 3 -> rsp_valid=01 and rsp_data=0x1234 at 4, grant=0 and stall[0]=0 at 4.
- Contention and fairness: req=11 held continuously, rr_ptr=0 -> grants alternate 01,10,01,10 over 4 transactions, each delivering its own tagged result.
- Timeout with TIMEOUT=15: grant to requester 1 and no result -> timeout_err pulses exactly once, 15 cycles into WAIT. rsp_valid stays 00, the next grant goes to requester 0 if pending, stall[1] stays 1.
- Wrong tag: requester 0 granted, res_out_valid=10 -> tag_err pulses, no response. The later res_out_valid=01 then delivers normally.
- Async reset asserted during WAIT -> all outputs at reset values immediately. A late res_out_valid=01 after release produces no rsp_valid and no tag_err.
- Request drop: req[0] deasserted during WAIT -> response still strobed on rsp_valid=01 with the correct data.

Source files
------------

// File: rtl/resource_grant_server_pkg.sv
// rtl/resource_grant_server_pkg.sv - shared state encoding and default sizing for the grant server
package resource_grant_server_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    localparam int DEF_NUM_REQ = 2;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 15;

    // Timer is sized for the largest supported TIMEOUT (255).
    localparam int TIMER_W = 8;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector starting at a pointer with wrap
module rr_pick #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         pick_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // First set request at or above ptr_i, wrapping past the top requester.
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] cand;
        int               j;
        pick_o = '0;
        idx_o  = '0;
        found  = 1'b0;
        cand   = '0;
        j      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr_i) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            cand = IDX_W'(j);
            if (!found && req_i[cand]) begin
                found        = 1'b1;
                pick_o[cand] = 1'b1;
                idx_o        = cand;
            end
        end
    end

endmodule

// File: rtl/resource_grant_server.sv
// rtl/resource_grant_server.sv - round-robin grant, tagged issue and response routing for a shared resource
module resource_grant_server
    import resource_grant_server_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        stall,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [DATA_W-1:0]         res_in,
    output logic [NUM_REQ-1:0]        res_in_valid,
    input  logic [DATA_W-1:0]         res_out,
    input  logic [NUM_REQ-1:0]        res_out_valid,
    output logic                      timeout_err,
    output logic                      tag_err,
    output logic                      busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
    logic                 timeout_err_q, timeout_err_d;
    logic                 tag_err_q, tag_err_d;

    logic [NUM_REQ-1:0]   pick;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W-1:0]     next_ptr;
    logic                 match;
    logic                 last_wait;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .req_i  (req),
        .ptr_i  (rr_ptr_q),
        .pick_o (pick),
        .idx_o  (pick_idx)
    );

    // Pointer moves past the served requester whether it completed or timed out.
    assign next_ptr  = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
    assign match     = (res_out_valid == grant_q);
    // This WAIT cycle is the last one in which a result is accepted.
    assign last_wait = (timer_q == TIMER_W'(TIMEOUT - 1));

    // Next-state and registered-output logic for the IDLE/ISSUE/WAIT sequence.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        idx_d         = idx_q;
        grant_d       = grant_q;
        timer_d       = timer_q;
        rsp_valid_d   = '0;
        rsp_data_d    = rsp_data_q;
        timeout_err_d = 1'b0;
        tag_err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d = pick;
                    idx_d   = pick_idx;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                timer_d = timer_q + 1'b1;
                if (match) begin
                    rsp_valid_d = grant_q;
                    rsp_data_d  = res_out;
                    grant_d     = '0;
                    rr_ptr_d    = next_ptr;
                    state_d     = IDLE;
                end else begin
                    if (|res_out_valid) begin
                        tag_err_d = 1'b1;
                    end
                    if (last_wait) begin
                        timeout_err_d = 1'b1;
                        grant_d       = '0;
                        rr_ptr_d      = next_ptr;
                        state_d       = IDLE;
                    end
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            idx_q         <= '0;
            grant_q       <= '0;
            timer_q       <= '0;
            rsp_valid_q   <= '0;
            rsp_data_q    <= '0;
            timeout_err_q <= 1'b0;
            tag_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            idx_q         <= idx_d;
            grant_q       <= grant_d;
            timer_q       <= timer_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            timeout_err_q <= timeout_err_d;
            tag_err_q     <= tag_err_d;
        end
    end

    assign res_in_valid = (state_q == ISSUE) ? grant_q : '0;
    assign res_in       = (state_q == ISSUE) ? req_data[idx_q*DATA_W +: DATA_W] : '0;
    assign grant        = grant_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign timeout_err  = timeout_err_q;
    assign tag_err      = tag_err_q;
    assign stall        = req & ~rsp_valid_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_resource_grant_server.sv
// tb/tb_resource_grant_server.sv - scoreboard bench for resource_grant_server
module tb_resource_grant_server;

    localparam int NUM_REQ = 2;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;

    localparam int K_RSP = 0;
    localparam int K_TO  = 1;
    localparam int K_TAG = 2;

    localparam int M_NORM = 0;
    localparam int M_WTAG = 1;
    localparam int M_TOUT = 2;
    localparam int M_DROP = 3;

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic [NUM_REQ-1:0]        req = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        stall;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic [DATA_W-1:0]         res_in;
    logic [NUM_REQ-1:0]        res_in_valid;
    logic [DATA_W-1:0]         res_out = '0;
    logic [NUM_REQ-1:0]        res_out_valid = '0;
    logic                      timeout_err;
    logic                      tag_err;
    logic                      busy;

    typedef struct {
        int                 kind;
        logic [NUM_REQ-1:0] tag;
        logic [DATA_W-1:0]  data;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   model_ptr = 0;

    resource_grant_server #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .req_data      (req_data),
        .grant         (grant),
        .stall         (stall),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .res_in        (res_in),
        .res_in_valid  (res_in_valid),
        .res_out       (res_out),
        .res_out_valid (res_out_valid),
        .timeout_err   (timeout_err),
        .tag_err       (tag_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // Reference arbitration: first requester at or after ptr, wrapping.
    function automatic logic [NUM_REQ-1:0] model_pick(input logic [NUM_REQ-1:0] r,
                                                       input int ptr, output int idx);
        for (int k = 0; k < NUM_REQ; k++) begin
            int j;
            j = (ptr + k) % NUM_REQ;
            if (r[j]) begin
                idx = j;
                return NUM_REQ'(1) << j;
            end
        end
        idx = 0;
        return '0;
    endfunction

    task automatic pop_check(input int kind);
        exp_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got kind %0d expected none", kind);
            return;
        end
        e = exp_q.pop_front();
        chk("event_kind", 64'(kind), 64'(e.kind));
        if (kind == K_RSP) begin
            chk("rsp_tag", 64'(rsp_valid), 64'(e.tag));
            chk("rsp_data", 64'(rsp_data), 64'(e.data));
            chk("grant_at_rsp", 64'(grant), 64'(0));
            chk("stall_at_rsp", 64'(stall & rsp_valid), 64'(0));
        end
    endtask

    // Monitor: invariants every cycle plus in-order scoreboard matching.
    always @(negedge clk) begin
        if (!reset) begin
            chk("grant_onehot0", 64'($onehot0(grant)), 64'(1));
            if (res_in_valid != '0) begin
                chk("res_in_valid_eq_grant", 64'(res_in_valid), 64'(grant));
            end
            if (tag_err) pop_check(K_TAG);
            if (rsp_valid != '0) pop_check(K_RSP);
            if (timeout_err) pop_check(K_TO);
        end
    end

    function automatic logic [NUM_REQ*DATA_W-1:0] rand_data();
        logic [NUM_REQ*DATA_W-1:0] v;
        for (int i = 0; i < NUM_REQ; i++) begin
            v[i*DATA_W +: DATA_W] = $urandom;
        end
        return v;
    endfunction

    task automatic do_txn(input logic [NUM_REQ-1:0] rp, input int mode, input int lat,
                          input logic [NUM_REQ*DATA_W-1:0] rd, input logic [DATA_W-1:0] res);
        int                 idx;
        logic [NUM_REQ-1:0] exp_g;
        bit                 seen;
        exp_t               e;
        seen     = 1'b0;
        req      = rp;
        req_data = rd;
        exp_g    = model_pick(rp, model_ptr, idx);
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (res_in_valid != '0) seen = 1'b1;
        end
        chk("issue_seen", 64'(seen), 64'(1));
        if (!seen) return;
        chk("grant", 64'(grant), 64'(exp_g));
        chk("res_in_valid", 64'(res_in_valid), 64'(exp_g));
        chk("res_in", 64'(res_in), 64'(rd[idx*DATA_W +: DATA_W]));
        model_ptr = (idx + 1) % NUM_REQ;
        if (mode == M_TOUT) begin
            e.kind = K_TO; e.tag = exp_g; e.data = '0;
            exp_q.push_back(e);
            repeat (TIMEOUT) @(negedge clk);
            chk("no_early_timeout", 64'(timeout_err), 64'(0));
            chk("busy_before_timeout", 64'(busy), 64'(1));
            @(negedge clk);
            chk("timeout_pulse", 64'(timeout_err), 64'(1));
            chk("no_rsp_on_timeout", 64'(rsp_valid), 64'(0));
            chk("stall_after_timeout", 64'(stall[idx]), 64'(rp[idx]));
            chk("idle_after_timeout", 64'(busy), 64'(0));
            return;
        end
        for (int k = 0; k <= lat; k++) begin
            @(posedge clk);
            #1;
            res_out_valid = '0;
            if (mode == M_WTAG && k == 0) begin
                e.kind = K_TAG; e.tag = exp_g; e.data = '0;
                exp_q.push_back(e);
                res_out_valid = {exp_g[NUM_REQ-2:0], exp_g[NUM_REQ-1]};
                res_out       = $urandom;
            end
            if (mode == M_DROP && k == 0) req[idx] = 1'b0;
            if (k == lat) begin
                e.kind = K_RSP; e.tag = exp_g; e.data = res;
                exp_q.push_back(e);
                res_out_valid = exp_g;
                res_out       = res;
            end
        end
        @(posedge clk);
        #1;
        res_out_valid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NUM_REQ-1:0] rp;
        int                 mode;
        int                 lat;
        bit                 seen;

        // Reset values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 64'(grant), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_data", 64'(rsp_data), 64'(0));
        chk("rst_res_in_valid", 64'(res_in_valid), 64'(0));
        chk("rst_res_in", 64'(res_in), 64'(0));
        chk("rst_errs", 64'({timeout_err, tag_err}), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Contention from pointer 0: 01,10,01,10.
        for (int t = 0; t < 4; t++) begin
            do_txn(2'b11, M_NORM, $urandom_range(0, 4), rand_data(), $urandom);
        end
        // Single request, result one WAIT cycle after entry.
        do_txn(2'b01, M_NORM, 1, {32'h0, 32'h0000_00A5}, 32'h0000_1234);
        // Timeout on requester 1 with requester 0 also pending.
        do_txn(2'b11, M_TOUT, 0, rand_data(), '0);
        // Wrong tag then correct tag.
        do_txn(2'b01, M_WTAG, 2, rand_data(), $urandom);
        // Request dropped during WAIT.
        do_txn(2'b01, M_DROP, 3, rand_data(), $urandom);

        for (int t = 0; t < 40; t++) begin
            rp   = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            mode = $urandom_range(0, 3);
            if (mode == M_TOUT && ($urandom_range(0, 2) != 0)) mode = M_NORM;
            lat  = $urandom_range((mode == M_WTAG) ? 1 : 0, 6);
            do_txn(rp, mode, lat, rand_data(), $urandom);
        end

        // Asynchronous reset during WAIT, then a late result.
        req = 2'b01;
        req_data = rand_data();
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (res_in_valid != '0) seen = 1'b1;
        end
        chk("rst_test_issue", 64'(seen), 64'(1));
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("midrst_grant", 64'(grant), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_res_in_valid", 64'(res_in_valid), 64'(0));
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
        req = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_ptr = 0;
        res_out_valid = 2'b01;
        res_out = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        res_out_valid = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("late_no_rsp", 64'(rsp_valid), 64'(0));
            chk("late_no_tag_err", 64'(tag_err), 64'(0));
        end
        @(posedge clk);
        #1;
        do_txn(2'b10, M_NORM, 2, rand_data(), $urandom);
        req = '0;
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
